// File: rtl/multi_core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_core_run_ctrl
// Purpose  : Run-sequencing controller for a multi-core processor array.
//            Launches a run on a host-selected subset of cores, tracks
//            per-core completion (sticky), counts RUN cycles (saturating)
//            and ends a run on full completion, timeout or host abort.
// Ports    :
//   clk, rst       - clock, asynchronous active-high reset
//   start          - host run request, honoured only in IDLE when ready
//   abort          - host abort, honoured only in RUN
//   core_mask      - cores to launch (bit i = core i), latched on start
//   timeout_limit  - max RUN cycles (0 = unlimited), latched on start
//   core_ready     - per-core ready
//   core_done      - per-core done (pulse or level)
//   core_start     - one-cycle launch pulse per selected core
//   ready          - controller can accept start this cycle
//   busy           - run in progress (any state other than IDLE)
//   done           - one-cycle run-complete pulse
//   err            - run status: 00 ok, 01 timeout, 10 abort
//   done_vec       - sticky per-core completion of the last/current run
//   cycle_count    - RUN cycles elapsed in the last/current run
// Revision : 1.0 - initial release
// ============================================================================
module multi_core_run_ctrl #(
    parameter int CORE_COUNT = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CORE_COUNT-1:0] core_mask,
    input  logic [CNT_WIDTH-1:0]  timeout_limit,
    input  logic [CORE_COUNT-1:0] core_ready,
    input  logic [CORE_COUNT-1:0] core_done,
    output logic [CORE_COUNT-1:0] core_start,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err,
    output logic [CORE_COUNT-1:0] done_vec,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_launch = 2'd1;
    localparam logic [1:0] c_st_run    = 2'd2;
    localparam logic [1:0] c_st_finish = 2'd3;

    localparam logic [1:0] c_err_ok      = 2'b00;
    localparam logic [1:0] c_err_timeout = 2'b01;
    localparam logic [1:0] c_err_abort   = 2'b10;

    logic [1:0]            r_state;
    logic [CORE_COUNT-1:0] r_active_mask;
    logic [CNT_WIDTH-1:0]  r_limit;
    logic [CORE_COUNT-1:0] r_core_start;
    logic                  r_done;
    logic [1:0]            r_err;
    logic [CORE_COUNT-1:0] r_done_vec;
    logic [CNT_WIDTH-1:0]  r_cycle_count;

    logic                  w_ready;
    logic [CORE_COUNT-1:0] w_done_merge;
    logic                  w_complete;
    logic [CNT_WIDTH:0]    w_cnt_inc;
    logic [CNT_WIDTH-1:0]  w_cnt_sat;
    logic                  w_timeout;

    // A start needs a non-empty mask whose cores are all ready.
    assign w_ready = (r_state == c_st_idle) &&
                     (core_mask != '0) &&
                     ((core_ready & core_mask) == core_mask);

    // Completion includes this cycle's done so a single-cycle done pulse on
    // the last outstanding core finishes the run without an extra cycle.
    assign w_done_merge = (r_done_vec | core_done) & r_active_mask;
    assign w_complete   = (w_done_merge == r_active_mask);

    // One extra bit keeps the carry so the counter can saturate, and so the
    // timeout compare stays correct once the counter is pinned at all-ones.
    assign w_cnt_inc = {1'b0, r_cycle_count} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign w_cnt_sat = w_cnt_inc[CNT_WIDTH] ? r_cycle_count : w_cnt_inc[CNT_WIDTH-1:0];
    assign w_timeout = (r_limit != '0) && (w_cnt_inc >= {1'b0, r_limit});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_active_mask <= '0;
            r_limit       <= '0;
            r_core_start  <= '0;
            r_done        <= 1'b0;
            r_err         <= c_err_ok;
            r_done_vec    <= '0;
            r_cycle_count <= '0;
        end else begin
            // Pulse outputs default low; they are raised on state entry.
            r_core_start <= '0;
            r_done       <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (start && w_ready) begin
                        r_active_mask <= core_mask;
                        r_limit       <= timeout_limit;
                        r_core_start  <= core_mask;
                        r_state       <= c_st_launch;
                    end
                end

                c_st_launch: begin
                    r_cycle_count <= '0;
                    r_done_vec    <= '0;
                    r_err         <= c_err_ok;
                    r_state       <= c_st_run;
                end

                c_st_run: begin
                    r_done_vec    <= w_done_merge;
                    r_cycle_count <= w_cnt_sat;
                    if (w_complete) begin
                        r_err   <= c_err_ok;
                        r_done  <= 1'b1;
                        r_state <= c_st_finish;
                    end else if (abort) begin
                        r_err   <= c_err_abort;
                        r_done  <= 1'b1;
                        r_state <= c_st_finish;
                    end else if (w_timeout) begin
                        r_err   <= c_err_timeout;
                        r_done  <= 1'b1;
                        r_state <= c_st_finish;
                    end
                end

                c_st_finish: begin
                    r_state <= c_st_idle;
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign core_start  = r_core_start;
    assign ready       = w_ready;
    assign busy        = (r_state != c_st_idle);
    assign done        = r_done;
    assign err         = r_err;
    assign done_vec    = r_done_vec;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_multi_core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_core_run_ctrl
// Purpose  : Self-checking bench for multi_core_run_ctrl. Each run's outcome
//            (end cycle, status, completion vector) is predicted from per-core
//            done times, abort time and timeout limit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_core_run_ctrl;

    localparam int N      = 4;
    localparam int CW     = 16;
    localparam int NEVER  = 1000;
    localparam int BUDGET = 200;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [N-1:0]  core_mask;
    logic [CW-1:0] timeout_limit;
    logic [N-1:0]  core_ready;
    logic [N-1:0]  core_done;
    logic [N-1:0]  core_start;
    logic          ready;
    logic          busy;
    logic          done;
    logic [1:0]    err;
    logic [N-1:0]  done_vec;
    logic [CW-1:0] cycle_count;

    int n_tests;
    int n_fail;
    int done_at [N];

    multi_core_run_ctrl #(
        .CORE_COUNT (N),
        .CNT_WIDTH  (CW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .core_mask     (core_mask),
        .timeout_limit (timeout_limit),
        .core_ready    (core_ready),
        .core_done     (core_done),
        .core_start    (core_start),
        .ready         (ready),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .done_vec      (done_vec),
        .cycle_count   (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Predicts the run outcome from event times: the run ends at the earliest
    // of completion / abort / timeout, with that priority on ties.
    task automatic run_case(input logic [N-1:0] mask, input int lim,
                            input bit level, input int ab);
        int            tc;
        int            ta;
        int            tl;
        int            exp_end;
        logic [1:0]    exp_err;
        logic [N-1:0]  exp_dv;
        logic [N-1:0]  d;
        logic [N-1:0]  noise;

        tc = 0;
        for (int i = 0; i < N; i++)
            if (mask[i] && done_at[i] > tc) tc = done_at[i];
        ta = (ab == 0) ? NEVER : ab;
        tl = (lim == 0) ? NEVER : lim;
        exp_end = tc;
        if (ta < exp_end) exp_end = ta;
        if (tl < exp_end) exp_end = tl;
        exp_err = (tc == exp_end) ? 2'b00 : ((ta == exp_end) ? 2'b10 : 2'b01);
        for (int i = 0; i < N; i++)
            exp_dv[i] = mask[i] && (done_at[i] <= exp_end);

        // IDLE: request the run
        @(negedge clk);
        core_mask     = mask;
        timeout_limit = CW'(lim);
        core_ready    = '1;
        core_done     = '0;
        abort         = 1'b0;
        start         = 1'b1;
        #1;
        chk("idle_ready", 32'(ready), 32'd1);

        // LAUNCH: garbage on every input must be ignored
        @(negedge clk);
        chk("launch_core_start", 32'(core_start), 32'(mask));
        chk("launch_busy", 32'(busy), 32'd1);
        start         = 1'($urandom);
        abort         = 1'($urandom);
        core_done     = N'($urandom);
        core_mask     = N'($urandom);
        timeout_limit = CW'($urandom);

        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("run1_core_start", 32'(core_start), 32'd0);
                chk("run1_cycle_count", 32'(cycle_count), 32'd0);
            end
            chk("run_busy_nodone", {30'd0, busy, done}, 32'b10);
            for (int i = 0; i < N; i++)
                d[i] = level ? (k >= done_at[i]) : (k == done_at[i]);
            noise      = N'($urandom);
            core_done  = (d & mask) | (noise & ~mask);
            abort      = (k == ab);
            start      = (k == ab) ? 1'b1 : 1'($urandom);
            core_ready = N'($urandom);
            if (k == exp_end) break;
            if (k == BUDGET) chk("run_end_bound", 32'(k), 32'(exp_end));
        end

        // FINISH
        @(negedge clk);
        start     = 1'b0;
        abort     = 1'b0;
        core_done = '0;
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_err", 32'(err), 32'(exp_err));
        chk("fin_done_vec", 32'(done_vec), 32'(exp_dv));
        chk("fin_cycle_count", 32'(cycle_count), 32'(exp_end));

        // back in IDLE, results held, no relaunch
        @(negedge clk);
        chk("post_busy_done", {30'd0, busy, done}, 32'b00);
        chk("post_core_start", 32'(core_start), 32'd0);
        chk("post_err", 32'(err), 32'(exp_err));
        chk("post_done_vec", 32'(done_vec), 32'(exp_dv));
        chk("post_cycle_count", 32'(cycle_count), 32'(exp_end));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        core_mask     = 4'h5;
        timeout_limit = '0;
        core_ready    = 4'hF;
        core_done     = '0;

        // reset / idle
        @(negedge clk);
        chk("rst_outputs", {17'd0, core_start, busy, done, err, done_vec}, 32'd0);
        chk("rst_cycle_count", 32'(cycle_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {17'd0, core_start, busy, done, err, done_vec}, 32'd0);
        chk("idle_ready_all", 32'(ready), 32'd1);
        core_ready = 4'h4;
        #1;
        chk("idle_ready_partial", 32'(ready), 32'd0);

        // normal run: cores finish at RUN cycles 3,5,2,7
        done_at = '{3, 5, 2, 7};
        run_case(4'hF, 0, 1'b0, 0);

        // partial mask: unmasked cores 0 and 3 finish early
        done_at = '{1, 4, 4, 2};
        run_case(4'h6, 0, 1'b0, 0);

        // timeout, then completion tying with timeout
        done_at = '{2, NEVER, NEVER, NEVER};
        run_case(4'h3, 10, 1'b0, 0);
        done_at = '{2, 10, NEVER, NEVER};
        run_case(4'h3, 10, 1'b0, 0);

        // abort in RUN cycle 3 with start pulsed
        done_at = '{NEVER, NEVER, NEVER, NEVER};
        run_case(4'hF, 0, 1'b1, 3);

        // abort in IDLE has no effect
        @(negedge clk);
        core_ready = 4'hF;
        core_mask  = 4'hF;
        abort      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_abort_busy", 32'(busy), 32'd0);
        abort = 1'b0;

        // start with empty mask ignored
        core_mask = 4'h0;
        start     = 1'b1;
        #1;
        chk("mask0_ready", 32'(ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("mask0_no_launch", {27'd0, core_start, busy}, 32'd0);

        // reset during LAUNCH drops core_start at once
        core_mask = 4'hF;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rstl_core_start", 32'(core_start), 32'hF);
        rst = 1'b1;
        #1;
        chk("rstl_core_start_drop", 32'(core_start), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // reset mid-run at RUN cycle 4
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            core_done = (k == 2) ? 4'h1 : 4'h0;
        end
        chk("mid_pre_done_vec", 32'(done_vec), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {17'd0, core_start, busy, done, err, done_vec}, 32'd0);
        chk("mid_rst_cycle_count", 32'(cycle_count), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        core_done = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_no_done", {30'd0, busy, done}, 32'd0);
        end
        done_at = '{3, 5, 2, 7};
        run_case(4'hF, 0, 1'b1, 0);

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            logic [N-1:0] m;
            int           lim;
            int           ab;
            int           tc;
            m   = N'($urandom_range(1, 15));
            lim = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 30));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
            tc  = 0;
            for (int i = 0; i < N; i++) begin
                done_at[i] = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(1, 25));
                if (m[i] && done_at[i] > tc) tc = done_at[i];
            end
            if (lim == 0 && ab == 0 && tc == NEVER) lim = 30;
            run_case(m, lim, 1'($urandom), ab);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_core_run_ctrl.md
Name: multi_core_run_ctrl

Overview:
Run-sequencing controller for a parametrised multi-core processor array. It launches a run on a runtime-selected subset of cores and tracks per-core completion, so cores no longer have to share core 0's done/ready status. It aggregates ready and done across the active cores only, counts run cycles, and ends a run on full completion, timeout or host abort. It sits between the host start/done interface and the CORE_COUNT core instances.

Parameters:
CORE_COUNT, 4, number of cores controlled (>=1)
CNT_WIDTH, 16, width of cycle counter and timeout limit

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  host run request (sampled only in IDLE)
abort  in  1  host abort request (effective only in RUN)
core_mask  in  CORE_COUNT  cores to launch; bit i = core i; sampled on accepted start
timeout_limit  in  CNT_WIDTH  max RUN cycles; 0 = no timeout; sampled on accepted start
core_ready  in  CORE_COUNT  per-core ready
core_done  in  CORE_COUNT  per-core done (pulse or level)
core_start  out  CORE_COUNT  one-cycle start pulse per launched core
ready  out  1  controller can accept start
busy  out  1  run in progress
done  out  1  one-cycle run-complete pulse
err  out  2  run status: 00 ok, 01 timeout, 10 abort
done_vec  out  CORE_COUNT  sticky per-core completion of the last/current run
cycle_count  out  CNT_WIDTH  RUN cycles elapsed in the last/current run

Behaviour:
- Reset (async, rst=1): state IDLE; core_start=0, done=0, busy=0, err=00, done_vec=0, cycle_count=0, internal active_mask=0, limit=0. ready is combinational from IDLE state and inputs.
- States: IDLE, LAUNCH, RUN, FINISH. busy=1 in every state except IDLE.
- IDLE: ready = (core_mask!=0) and (core_ready & core_mask)==core_mask.
  - start=1 and ready=1: latch active_mask<=core_mask and limit<=timeout_limit, then go to LAUNCH.
  - start with ready=0 (including mask=0): ignored, no state change.
- LAUNCH (exactly 1 cycle): core_start=active_mask (registered, high this cycle only). cycle_count<=0, done_vec<=0, err<=00. core_done in this cycle is ignored. Next state: RUN.
- RUN, evaluated each cycle in this priority order:
  1. done_vec <= done_vec | (core_done & active_mask); sticky.
  2. cycle_count <= cycle_count+1, saturating at all-ones.
  3. complete = ((done_vec | core_done) & active_mask) == active_mask. If complete, go to FINISH with err=00. Completion beats timeout and abort in the same cycle.
  4. Otherwise, if abort=1, go to FINISH with err=10.
  5. Otherwise, if limit!=0 and cycle_count+1 >= limit, go to FINISH with err=01.
  6. Otherwise stay in RUN.
- FINISH (1 cycle): done=1; then go to IDLE. err, done_vec and cycle_count hold until the next LAUNCH.
- start is ignored in LAUNCH, RUN and FINISH. abort is ignored outside RUN.
- core_mask and timeout_limit changes during a run have no effect; the latched copies are used.
- Unmasked cores' done/ready are ignored for the whole run; their done_vec bits stay 0.
- Latency: accepted start -> core_start next cycle. Minimum run (done seen in the first RUN cycle): start accepted at cycle 0, LAUNCH cycle 1, RUN cycle 2, done pulse cycle 3, cycle_count=1.
- rst asserted mid-run: immediate return to reset values; no done pulse; core_start drops at once.
- Widths: all vectors are CORE_COUNT bits with bit i = core i. cycle_count has no wrap; it saturates.

Test Plan:
- Reset/idle: rst=1 then 0, core_ready=4'hF, core_mask=4'h5 -> all outputs 0 except ready=1. core_ready=4'h4 -> ready=0.
- Normal run: mask=4'hF, limit=0, start -> core_start=4'hF for 1 cycle. Cores done at RUN cycles 3, 5, 2, 7 (cores 0..3) -> done pulse the cycle after RUN cycle 7, err=00, done_vec=4'hF, cycle_count=7.
- Partial mask: mask=4'h6, core 0 and core 3 pulse done early, cores 1 and 2 done at RUN cycle 4 -> core_start=4'h6, done_vec=4'h6, cycle_count=4, err=00.
- Timeout: mask=4'h3, limit=10, only core 0 done -> FINISH after RUN cycle 10, err=01, cycle_count=10, done_vec=4'h1. Same setup with core 1 done at RUN cycle 10 -> err=00.
- Abort and ignored start: abort in RUN cycle 3 with start also pulsed -> err=10, cycle_count=3, no relaunch. Abort in IDLE -> no effect. start with mask=0 -> ignored.
- Reset mid-run: rst at RUN cycle 4 -> busy=0, done never pulses, cycle_count=0, done_vec=0; next start launches normally.
